seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Display stage directly downstream of the counter. Takes a BW-bit binary value
//  (e.g. counter_val_o) and drives a multiplexed, common-cathode hex 7-segment
//  display of NDIG = (BW+3)/4 digits.
//  A refresh divider paces the digit scan. The value is snapshotted once per scan
//  frame so a frame never shows two different values.
// PARAMETERS
//  BW       8   width of value_i; NDIG = (BW+3)/4; top nibble zero-extended
//  DIV      4   clk cycles each digit is held (>=1; 1 = advance every cycle)
//  BLANK_LZ 0   1 = blank leading zero digits (digit 0 never blanked)
// PORTS
//  clk_i    in   1     system clock, rising edge
//  nrst_i   in   1     async active-low reset
//  en_i     in   1     display enable, sampled into en_q
//  value_i  in   BW    binary value to display
//  seg_o    out  7     segments {g,f,e,d,c,b,a}, active-high (seg_o[0]=a)
//  dig_o    out  NDIG  digit select, one-hot, active-high (dig_o[0]=least significant nibble)
//  frame_o  out  1     1-cycle pulse in the last cycle of each scan frame
// BEHAVIOUR
//  Reset (nrst_i=0, async)
//   - en_q=0, div=0, idx=0, shadow=0
//   - seg_o=0, dig_o=0, frame_o=0 for as long as reset is held
//  Enable
//   - en_q <= en_i every edge: one cycle latency on both enable and disable.
//  Disabled (en_q=0)
//   - div=0 and idx=0 on every edge
//   - shadow <= value_i on every edge
//   - seg_o=0, dig_o=0, frame_o=0
//  Divider (en_q=1)
//   - div counts 0..DIV-1 and wraps to 0.
//   - At div==DIV-1: idx <= (idx==NDIG-1) ? 0 : idx+1.
//   - Frame length = NDIG*DIV cycles. Digit 0 is shown first after enable.
//  Snapshot
//   - When en_q=1, div==DIV-1 and idx==NDIG-1: shadow <= value_i, and frame_o=1
//     in that same cycle.
//   - At all other times while enabled, shadow holds. A value_i change mid-frame
//     appears from the next frame.
//  Outputs
//   - dig_o = en_q ? (1<<idx) : 0
//   - seg_o = decode of nibble idx of zero-extended shadow, gated by en_q
//   - Both are combinational from registers only; no path from value_i or en_i.
//  Decode (hex -> seg_o)
//   - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  Leading-zero blanking (BLANK_LZ=1)
//   - Digit k>0 shows seg_o=0 when shadow nibbles k..NDIG-1 are all zero.
//   - dig_o still asserts for that digit, so scan timing is unchanged.
//  Reset mid-operation
//   - Outputs go to 0 immediately (async).
//   - Scan restarts at digit 0 with a fresh snapshot.
// TESTING
//  (BW=8, DIV=4, BLANK_LZ=0 unless stated)
//  1. Reset/enable: nrst_i=0 -> seg_o=0, dig_o=0.
//     Release with en_i=1, value_i=8'hA5 -> after en_q rises:
//     dig_o=01, seg_o=6D for 4 cycles; then dig_o=10, seg_o=77 for 4 cycles; repeat.
//  2. Frame pulse: en steady -> frame_o high exactly 1 cycle in 8, in the last
//     cycle of digit 1; first pulse 8 cycles after en_q rises.
//  3. Snapshot: value_i 8'hA5 -> 8'h3C during digit 0 -> digit 1 still shows 77
//     (A) this frame; next frame shows 39 (C) then 4F (3).
//  4. Disable: drop en_i mid-frame -> one cycle later dig_o=0, seg_o=0,
//     frame_o stays 0.
//     Re-enable -> scan restarts at digit 0 showing the current value_i.
//  5. BLANK_LZ=1, value_i=8'h07 -> digit 0 seg_o=07; digit 1 seg_o=00 with dig_o=10.
//     value_i=8'h00 -> digit 0 shows 3F.
//  6. BW=3, DIV=1, value_i sweeps 0..7 (counter wrap 7->0) -> dig_o=1 constantly,
//     frame_o=1 every cycle, seg_o follows the table with 1 cycle latency.
//     Async reset mid-scan zeroes outputs before the next edge.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-cathode hex 7-segment driver: scans NDIG digits at a divided rate
// and shows one value snapshot per scan frame, so a frame never mixes two values.
module seg7_scan_driver #(
  parameter int BW       = 8,
  parameter int DIV      = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  en_i,
  input  logic [BW-1:0]         value_i,
  output logic [6:0]            seg_o,
  output logic [(BW+3)/4-1:0]   dig_o,
  output logic                  frame_o
);

  localparam int NDIG = (BW + 3) / 4;
  localparam int SW   = NDIG * 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic          en_q;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [SW-1:0] shadow;

  logic          last_div;
  logic          last_idx;
  logic [3:0]    nib;
  logic [SW-1:0] upper;
  logic          blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign last_div = (div == DW'(DIV - 1));
  assign last_idx = (idx == IW'(NDIG - 1));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      en_q   <= 1'b0;
      div    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      en_q <= en_i;
      if (!en_q) begin
        // Idle: keep tracking the input so re-enable starts on a fresh value.
        div    <= '0;
        idx    <= '0;
        shadow <= SW'(value_i);
      end else if (last_div) begin
        div <= '0;
        if (last_idx) begin
          idx    <= '0;
          shadow <= SW'(value_i);
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  // Outputs depend only on registers; en_q gating also covers async reset.
  always_comb begin
    nib     = 4'(shadow >> (4 * idx));
    upper   = shadow >> (4 * idx);
    blank   = (BLANK_LZ != 0) && (idx != '0) && (upper == '0);
    seg_o   = (en_q && !blank) ? hex_to_seg(nib) : 7'h00;
    dig_o   = en_q ? (NDIG'(1) << idx) : '0;
    frame_o = en_q && last_div && last_idx;
  end

endmodule
